// File: rtl/rvm_sim_monitor.sv
// rvm_sim_monitor: snoops accepted accesses on the rvm_core memory bus, counts
// run cycles and ends a run on a watch-address hit, an Nth-hit condition or a
// cycle timeout. The outcome is held in sticky status registers until reset or re-arm.
module rvm_sim_monitor #(
    parameter int                ADDR_W    = 32,
    parameter int                N_WATCH   = 4,
    parameter int                CNT_W     = 32,
    parameter int                HIT_W     = 4,
    parameter logic [ADDR_W-1:0] ADDR_MASK = 32'h0FFF_FFFF,
    localparam int               IDX_W     = (N_WATCH > 1) ? $clog2(N_WATCH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [1:0]        cfg_kind,
    input  logic [HIT_W-1:0]  cfg_hits,
    input  logic [CNT_W-1:0]  max_cycles,
    input  logic              arm,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_c_en,
    input  logic              mem_stall,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        cause,
    output logic [IDX_W-1:0]  hit_idx,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam logic [1:0] KIND_OFF  = 2'b00;
    localparam logic [1:0] KIND_PASS = 2'b01;
    localparam logic [1:0] KIND_FAIL = 2'b10;
    localparam logic [1:0] KIND_HALT = 2'b11;

    localparam logic [HIT_W-1:0] HIT_ZERO = {HIT_W{1'b0}};
    localparam logic [HIT_W-1:0] HIT_ONE  = {{(HIT_W-1){1'b0}}, 1'b1};
    localparam logic [HIT_W-1:0] HIT_MAX  = {HIT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Arbitration weight of a channel kind: fail beats halt beats pass.
    function automatic logic [1:0] kind_rank(input logic [1:0] kind);
        logic [1:0] rank;
        case (kind)
            KIND_FAIL: rank = 2'd3;
            KIND_HALT: rank = 2'd2;
            KIND_PASS: rank = 2'd1;
            default:   rank = 2'd0;
        endcase
        return rank;
    endfunction

    state_t            state_r;
    logic [CNT_W-1:0]  lim_r;
    logic [ADDR_W-1:0] addr_r    [N_WATCH];
    logic [1:0]        kind_r    [N_WATCH];
    logic [HIT_W-1:0]  hits_r    [N_WATCH];
    logic [HIT_W-1:0]  hit_cnt_r [N_WATCH];

    logic              qual_s;
    logic [N_WATCH-1:0] match_s;
    logic [N_WATCH-1:0] fire_s;
    logic [HIT_W-1:0]  thr_s      [N_WATCH];
    logic [HIT_W-1:0]  hit_next_s [N_WATCH];
    logic              win_any_s;
    logic [IDX_W-1:0]  win_idx_s;
    logic [1:0]        win_kind_s;
    logic [1:0]        win_rank_s;
    logic              take_s;
    logic              timeout_s;
    logic [CNT_W-1:0]  cnt_next_s;

    // Per-channel address match, saturating hit-count update and fire decision.
    always_comb begin
        qual_s = mem_c_en & ~mem_stall;
        for (int i = 0; i < N_WATCH; i++) begin
            match_s[i]    = (kind_r[i] != KIND_OFF) && qual_s &&
                            ((mem_addr & ADDR_MASK) == (addr_r[i] & ADDR_MASK));
            thr_s[i]      = (hits_r[i] == HIT_ZERO) ? HIT_ONE : hits_r[i];
            hit_next_s[i] = (match_s[i] && (hit_cnt_r[i] != HIT_MAX)) ?
                            (hit_cnt_r[i] + HIT_ONE) : hit_cnt_r[i];
            fire_s[i]     = match_s[i] && (hit_next_s[i] >= thr_s[i]);
        end
    end

    // Pick the winning channel among simultaneous fires; strict compare keeps the lowest index on ties.
    always_comb begin
        win_any_s  = 1'b0;
        win_idx_s  = {IDX_W{1'b0}};
        win_kind_s = KIND_OFF;
        win_rank_s = 2'd0;
        take_s     = 1'b0;
        for (int i = 0; i < N_WATCH; i++) begin
            take_s     = fire_s[i] && (kind_rank(kind_r[i]) > win_rank_s);
            win_any_s  = take_s ? 1'b1 : win_any_s;
            win_idx_s  = take_s ? IDX_W'(i) : win_idx_s;
            win_kind_s = take_s ? kind_r[i] : win_kind_s;
            win_rank_s = take_s ? kind_rank(kind_r[i]) : win_rank_s;
        end
    end

    // Saturating cycle counter increment and timeout detection on the pre-increment value.
    always_comb begin
        cnt_next_s = (cycle_count == CNT_MAX) ? cycle_count : (cycle_count + CNT_ONE);
        timeout_s  = (lim_r != CNT_ZERO) && (cycle_count == (lim_r - CNT_ONE));
    end

    // Run-control state machine, channel configuration and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            lim_r       <= CNT_ZERO;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            cause       <= KIND_OFF;
            hit_idx     <= {IDX_W{1'b0}};
            cycle_count <= CNT_ZERO;
            for (int i = 0; i < N_WATCH; i++) begin
                addr_r[i]    <= {ADDR_W{1'b0}};
                kind_r[i]    <= KIND_OFF;
                hits_r[i]    <= HIT_ZERO;
                hit_cnt_r[i] <= HIT_ZERO;
            end
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    // Config is only writable outside a run; a write alongside arm applies to that run.
                    for (int i = 0; i < N_WATCH; i++) begin
                        if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                            addr_r[i] <= cfg_addr;
                            kind_r[i] <= cfg_kind;
                            hits_r[i] <= cfg_hits;
                        end
                    end
                    if (arm) begin
                        state_r     <= ST_RUN;
                        lim_r       <= max_cycles;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        cause       <= KIND_OFF;
                        hit_idx     <= {IDX_W{1'b0}};
                        cycle_count <= CNT_ZERO;
                        for (int i = 0; i < N_WATCH; i++) begin
                            hit_cnt_r[i] <= HIT_ZERO;
                        end
                    end
                end
                ST_RUN: begin
                    cycle_count <= cnt_next_s;
                    for (int i = 0; i < N_WATCH; i++) begin
                        hit_cnt_r[i] <= hit_next_s[i];
                    end
                    if (win_any_s) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (win_kind_s == KIND_PASS);
                        cause   <= win_kind_s;
                        hit_idx <= win_idx_s;
                    end else if (timeout_s) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        cause   <= KIND_OFF;
                        hit_idx <= {IDX_W{1'b0}};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rvm_sim_monitor.md
# rvm_sim_monitor

Synthesisable, parametrised run monitor for the rvm_core memory bus. It sits beside the core, snoops every accepted bus access and counts run cycles. It ends a run on the first of three events: a programmable watch-address hit (pass, fail or halt), an Nth-hit condition, or a cycle timeout. Results are reported through sticky status registers, so benches and FPGA harnesses share one pass/fail mechanism.

## Interface
Parameters:
- ADDR_W, 32, bus address width
- N_WATCH, 4, number of watch channels (>=1)
- CNT_W, 32, cycle counter width
- HIT_W, 4, per-channel hit-count width
- ADDR_MASK, 32'h0FFF_FFFF, mask applied to both bus and watch addresses before compare

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- cfg_we  in  1  write config of channel cfg_idx
- cfg_idx  in  max(1,$clog2(N_WATCH))  channel to write
- cfg_addr  in  ADDR_W  watch address
- cfg_kind  in  2  00 off, 01 pass, 10 fail, 11 halt
- cfg_hits  in  HIT_W  hits needed to fire; 0 treated as 1
- max_cycles  in  CNT_W  timeout limit; 0 = no timeout; sampled on arm
- arm  in  1  start a run (one-cycle pulse)
- mem_addr  in  ADDR_W  core bus address
- mem_c_en  in  1  core bus chip enable
- mem_stall  in  1  memory stall
- busy  out  1  run in progress
- done  out  1  run finished, sticky
- pass  out  1  done with cause pass
- cause  out  2  00 timeout, 01 pass, 10 fail, 11 halt; valid when done
- hit_idx  out  max(1,$clog2(N_WATCH))  firing channel; 0 on timeout
- cycle_count  out  CNT_W  RUN cycles elapsed, saturating

## Operation
- States: IDLE, RUN, DONE.
- Reset: state IDLE. All outputs 0. All channels kind=off, addr=0, hits=0. Hit counters 0. Latched limit 0.
- Config: cfg_we writes channel cfg_idx in IDLE or DONE only; ignored in RUN. cfg_idx >= N_WATCH is ignored.
- IDLE/DONE + arm: clear cycle_count, all hit counters, done, pass, cause and hit_idx. Latch max_cycles. Go to RUN. cfg_we and arm in the same cycle: the config write takes effect for the run being armed.
- RUN, each cycle:
  - cycle_count increments, saturating at all-ones.
  - Qualified access = mem_c_en & !mem_stall.
  - Channel match = kind != off & qualified & (mem_addr & ADDR_MASK) == (cfg_addr & ADDR_MASK).
  - A match increments that channel's hit counter, saturating.
  - A channel fires when its post-increment count >= max(cfg_hits,1).
- Firing: go to DONE, set done=1 and cause=kind. pass=1 only for kind 01.
- Multiple channels firing in the same cycle: priority fail > halt > pass, then lowest index. hit_idx is the winner.
- Timeout: limit L != 0 and pre-increment cycle_count == L-1 -> DONE with cause 00 and cycle_count = L. A watch fire in the same cycle wins over timeout.
- arm during RUN is ignored.
- DONE holds all outputs until reset or a new arm.
- busy = (state == RUN).

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- A qualifying access sampled at edge k sets done, cause and hit_idx visible after edge k, with latency 1.
- cycle_count = 1 after the first RUN edge following the arm edge.
- busy rises the cycle after arm and falls in the same cycle done rises.
- A reset asserted mid-run returns to IDLE on the next edge and discards config. There is no partial status.

## Test plan
- Reset, then write ch0 = {0x100, pass, hits 1}, max_cycles=50, arm. Drive an access to 0x1000_0100 at RUN cycle 7 -> done=1, pass=1, cause=01, hit_idx=0, cycle_count=7, all one cycle later.
- Same setup with mem_stall=1 during the access. Access is not counted, then timeout -> cause=00, pass=0, cycle_count=50, busy=0.
- ch1 = {0x200, fail, hits 3}. Drive accesses to 0x200 on RUN cycles 2, 5 and 9 -> done only after the third access, cause=10, hit_idx=1, cycle_count=9.
- ch0 pass @0x300 and ch2 fail @0x300, single access -> cause=10, hit_idx=2. Watch hit on the timeout cycle (L=4, access at cycle 4) -> cause is the watch kind, not 00.
- max_cycles=0 with no matching accesses for 1000 cycles -> busy stays 1, done=0. Assert reset mid-run -> next cycle all outputs 0 and all channels off.
- cfg_we to ch0 during RUN is ignored, and arm during RUN is ignored. Re-arm from DONE -> counters cleared, new run completes normally.
